// File: rtl/kbd_pkg.sv
// +-----------------------------------------------------------------------+
// | kbd_pkg: scan-code constants, parser states and event entry layout.  |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_STOP   = 8'h07;
  localparam logic [7:0] SC_SUPER  = 8'h7E;

  // Pause is E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam int ENTRY_W   = 13;
  localparam int CODE_LSB  = 0;
  localparam int FLAGS_LSB = 8;
  localparam int F_SHIFT   = 8;
  localparam int F_CTRL    = 9;
  localparam int F_ALT     = 10;
  localparam int F_EXT     = 11;
  localparam int F_REP     = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } parse_state_e;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic rep, input logic ext,
                                                  input logic alt, input logic ctrl,
                                                  input logic shift, input logic [7:0] code);
    return {rep, ext, alt, ctrl, shift, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_fifo.sv
// +-----------------------------------------------------------------------+
// | kbd_fifo: synchronous FIFO, simultaneous push/pop, full/empty flags. |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module kbd_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q;
  logic               do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/kbd_event_queue.sv
// +-----------------------------------------------------------------------+
// | kbd_event_queue: PS/2 make/break parser, modifiers, auto-repeat,     |
// | STOP/SUPER pulses and a key-event FIFO.                 Rev 1.0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module kbd_event_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned PULSE_LEN     = 256,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 20'd500000,
  parameter int unsigned REPEAT_PERIOD = 20'd100000
) (
  input  logic       mclk,
  input  logic       reset_in,
  input  logic       scan_dav,
  input  logic [7:0] scan_code,
  input  logic       scan_err,
  input  logic       read_kb,
  input  logic       clr_ovf,
  output logic       kbd_available,
  output logic [7:0] ev_code,
  output logic [4:0] ev_flags,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
  output logic       key_down,
  output logic       key_stop,
  output logic       key_super,
  output logic       overflow
);

  import kbd_pkg::*;

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? int'(REPEAT_DELAY) : int'(REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX + 1);
  localparam int PW   = $clog2(PULSE_LEN + 1);

  parse_state_e       state_q, state_d;
  logic [2:0]         skip_q, skip_d;
  logic               lsh_q, lsh_d, rsh_q, rsh_d;
  logic               lctl_q, lctl_d, rctl_q, rctl_d;
  logic               lalt_q, lalt_d, ralt_q, ralt_d;
  logic [7:0]         held_q, held_d;
  logic               held_ext_q, held_ext_d;
  logic               key_down_q, key_down_d;
  logic [RW-1:0]      rep_q, rep_d;
  logic [PW-1:0]      stop_q, stop_d, super_q, super_d;
  logic               push_q, push_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               ovf_q, ovf_d;

  logic               is_make, is_brk, is_ext;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty, drop;

  assign shift = lsh_q | rsh_q;
  assign ctrl  = lctl_q | rctl_q;
  assign alt   = lalt_q | ralt_q;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    lsh_d      = lsh_q;
    rsh_d      = rsh_q;
    lctl_d     = lctl_q;
    rctl_d     = rctl_q;
    lalt_d     = lalt_q;
    ralt_d     = ralt_q;
    held_d     = held_q;
    held_ext_d = held_ext_q;
    key_down_d = key_down_q;
    rep_d      = rep_q;
    stop_d     = (stop_q != '0) ? stop_q - PW'(1) : stop_q;
    super_d    = (super_q != '0) ? super_q - PW'(1) : super_q;
    push_d     = 1'b0;
    entry_d    = '0;
    is_make    = 1'b0;
    is_brk     = 1'b0;
    is_ext     = 1'b0;

    // A repeat is skipped, not deferred, while anything is still waiting for the CPU.
    if (REPEAT_EN != 0 && key_down_q && rep_q != '0) begin
      rep_d = rep_q - RW'(1);
      if (rep_q == RW'(1)) begin
        rep_d = RW'(REPEAT_PERIOD);
        if (fifo_empty && !push_q) begin
          push_d  = 1'b1;
          entry_d = mk_entry(1'b1, held_ext_q, alt, ctrl, shift, held_q);
        end
      end
    end

    if (scan_err) begin
      state_d = ST_IDLE;
    end else if (scan_dav) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_EXT)        state_d = ST_EXT;
          else if (scan_code == SC_BREAK) state_d = ST_BRK;
          else if (scan_code == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else is_make = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_BREAK) state_d = ST_EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_brk  = 1'b1;
          is_ext  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // E0 12 / E0 59 are the fake shifts some keys wrap themselves in.
    if ((is_make || is_brk) && !(is_ext && (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT))) begin
      if (scan_code == SC_LSHIFT)      lsh_d = is_make;
      else if (scan_code == SC_RSHIFT) rsh_d = is_make;
      else if (scan_code == SC_CTRL) begin
        if (is_ext) rctl_d = is_make;
        else        lctl_d = is_make;
      end else if (scan_code == SC_ALT) begin
        if (is_ext) ralt_d = is_make;
        else        lalt_d = is_make;
      end else if (is_make && !is_ext && scan_code == SC_STOP) begin
        stop_d = PW'(PULSE_LEN);
      end else if (is_make && !is_ext && scan_code == SC_SUPER) begin
        super_d = PW'(PULSE_LEN);
      end else if (is_make) begin
        if (!(key_down_q && held_q == scan_code && held_ext_q == is_ext)) begin
          push_d     = 1'b1;
          entry_d    = mk_entry(1'b0, is_ext, alt, ctrl, shift, scan_code);
          held_d     = scan_code;
          held_ext_d = is_ext;
          key_down_d = 1'b1;
          rep_d      = RW'(REPEAT_DELAY);
        end
      end else if (key_down_q && held_q == scan_code && held_ext_q == is_ext) begin
        key_down_d = 1'b0;
        rep_d      = '0;
        push_d     = 1'b0;
        entry_d    = '0;
      end
    end
  end

  assign drop  = push_q && fifo_full && !read_kb;
  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      lctl_q     <= 1'b0;
      rctl_q     <= 1'b0;
      lalt_q     <= 1'b0;
      ralt_q     <= 1'b0;
      held_q     <= '0;
      held_ext_q <= 1'b0;
      key_down_q <= 1'b0;
      rep_q      <= '0;
      stop_q     <= '0;
      super_q    <= '0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      lctl_q     <= lctl_d;
      rctl_q     <= rctl_d;
      lalt_q     <= lalt_d;
      ralt_q     <= ralt_d;
      held_q     <= held_d;
      held_ext_q <= held_ext_d;
      key_down_q <= key_down_d;
      rep_q      <= rep_d;
      stop_q     <= stop_d;
      super_q    <= super_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      ovf_q      <= ovf_d;
    end
  end

  kbd_fifo #(
    .DEPTH   (int'(DEPTH)),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (mclk),
    .rst     (reset_in),
    .push_i  (push_q),
    .din_i   (entry_q),
    .pop_i   (read_kb),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kbd_available = !fifo_empty;
  assign ev_code       = fifo_empty ? 8'h00 : head[CODE_LSB +: 8];
  assign ev_flags      = fifo_empty ? 5'h00 : head[FLAGS_LSB +: 5];
  assign key_down      = key_down_q;
  assign key_stop      = (stop_q != '0);
  assign key_super     = (super_q != '0);
  assign overflow      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_queue.sv
// +-----------------------------------------------------------------------+
// | tb_kbd_event_queue: directed + random stimulus vs. a byte-sequence   |
// | reference model of the keyboard event queue.            Rev 1.0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_kbd_event_queue;

  localparam int DEPTH = 4;
  localparam int PULSE = 8;
  localparam int RDLY  = 10;
  localparam int RPER  = 4;

  logic       mclk = 1'b0, reset_in = 1'b1;
  logic       scan_dav = 1'b0, scan_err = 1'b0, read_kb = 1'b0, clr_ovf = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       kbd_available, shift, ctrl, alt, key_down, key_stop, key_super, overflow;
  logic [7:0] ev_code;
  logic [4:0] ev_flags;

  kbd_event_queue #(
    .DEPTH(DEPTH), .PULSE_LEN(PULSE), .REPEAT_EN(1),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .mclk(mclk), .reset_in(reset_in), .scan_dav(scan_dav), .scan_code(scan_code),
    .scan_err(scan_err), .read_kb(read_kb), .clr_ovf(clr_ovf),
    .kbd_available(kbd_available), .ev_code(ev_code), .ev_flags(ev_flags),
    .shift(shift), .ctrl(ctrl), .alt(alt), .key_down(key_down),
    .key_stop(key_stop), .key_super(key_super), .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: event list, pressed-modifier set, pending byte prefix, absolute deadlines.
  logic [12:0] mq[$];
  bit          pv;
  logic [12:0] pe;
  bit          npv;
  logic [12:0] npe;
  bit          movf;
  logic [7:0]  pfx[$];
  bit          mods[int];
  bit          hkd;
  logic [7:0]  hcode;
  bit          hext;
  longint      t, next_rep, stop_until, super_until;

  function automatic bit m_shift(); return mods.exists(32'h012) || mods.exists(32'h059); endfunction
  function automatic bit m_ctrl();  return mods.exists(32'h014) || mods.exists(32'h114); endfunction
  function automatic bit m_alt();   return mods.exists(32'h011) || mods.exists(32'h111); endfunction

  task automatic model_reset();
    mq.delete(); pfx.delete(); mods.delete();
    pv = 0; pe = '0; movf = 0; hkd = 0; hcode = 8'h00; hext = 0;
    next_rep = 0; stop_until = 0; super_until = 0;
  endtask

  task automatic model_key(input bit make, input bit ext, input logic [7:0] c);
    int key;
    key = ext ? 256 + int'(c) : int'(c);
    if (ext && (c == 8'h12 || c == 8'h59)) return;
    if (c == 8'h12 || c == 8'h59 || c == 8'h14 || c == 8'h11) begin
      if (make) mods[key] = 1'b1;
      else if (mods.exists(key)) mods.delete(key);
      return;
    end
    if (make && !ext && c == 8'h07) begin stop_until = t + PULSE; return; end
    if (make && !ext && c == 8'h7E) begin super_until = t + PULSE; return; end
    if (make) begin
      if (!(hkd && c == hcode && ext == hext)) begin
        npv = 1; npe = {1'b0, ext, m_alt(), m_ctrl(), m_shift(), c};
        hcode = c; hext = ext; hkd = 1; next_rep = t + RDLY;
      end
    end else if (hkd && c == hcode && ext == hext) begin
      hkd = 0; npv = 0;
    end
  endtask

  task automatic model_edge(input bit dav, input logic [7:0] code, input bit err,
                            input bit rd, input bit clr);
    int n;
    bit popd, drop, was_pv;
    t++;
    n = mq.size(); was_pv = pv; popd = rd && (n > 0); drop = 0;
    if (popd) void'(mq.pop_front());
    if (pv) begin
      if (n < DEPTH || popd) mq.push_back(pe);
      else drop = 1;
    end
    if (drop) movf = 1; else if (clr) movf = 0;
    npv = 0; npe = '0;
    if (hkd && t == next_rep) begin
      next_rep = t + RPER;
      if (n == 0 && !was_pv) begin
        npv = 1; npe = {1'b1, hext, m_alt(), m_ctrl(), m_shift(), hcode};
      end
    end
    if (err) pfx.delete();
    else if (dav) begin
      if (pfx.size() == 0) begin
        if (code == 8'hE0 || code == 8'hF0 || code == 8'hE1) pfx.push_back(code);
        else model_key(1, 0, code);
      end else if (pfx[0] == 8'hE1) begin
        pfx.push_back(code);
        if (pfx.size() == 8) pfx.delete();
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
        if (code == 8'hF0) pfx.push_back(code);
        else begin pfx.delete(); model_key(1, 1, code); end
      end else if (pfx.size() == 1) begin
        pfx.delete(); model_key(0, 0, code);
      end else begin
        pfx.delete(); model_key(0, 1, code);
      end
    end
    pv = npv; pe = npe;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("avail", {31'd0, kbd_available}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("ev_code", {24'd0, ev_code}, {24'd0, mq[0][7:0]});
      chk("ev_flags", {27'd0, ev_flags}, {27'd0, mq[0][12:8]});
    end
    chk("mods", {29'd0, shift, ctrl, alt}, {29'd0, m_shift(), m_ctrl(), m_alt()});
    chk("key_down", {31'd0, key_down}, {31'd0, hkd});
    chk("pulses", {30'd0, key_stop, key_super}, {30'd0, t < stop_until, t < super_until});
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {11'd0, kbd_available, ev_code, ev_flags, shift, ctrl, alt, key_down,
              key_stop, key_super, overflow}, 32'd0);
  endtask

  task automatic step(input bit dav, input logic [7:0] code, input bit err,
                      input bit rd, input bit clr);
    scan_dav = dav; scan_code = code; scan_err = err; read_kb = rd; clr_ovf = clr;
    @(posedge mclk);
    model_edge(dav, code, err, rd, clr);
    cyc++;
    #1;
    check_all();
    scan_dav = 0; scan_err = 0; read_kb = 0; clr_ovf = 0;
  endtask

  task automatic send(input logic [7:0] b); step(1, b, 0, 0, 0); endtask
  task automatic send_r(input logic [7:0] b); step(1, b, 0, $urandom_range(0, 3) == 0, 0); endtask
  task automatic pop(); step(0, 8'h00, 0, 1, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0); endtask
  task automatic drain(); for (int i = 0; i < 12 && kbd_available; i++) pop(); endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tm[8];
    logic [4:0] fl[8];
    int na, cnt, hc, r;
    logic [7:0] b;
    logic [7:0] pool[4];
    logic [7:0] ovf_codes[9];
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
    ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    for (int i = 0; i < 8; i++) begin tm[i] = 0; fl[i] = '0; end
    t = 0;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    chk_zero("reset_state");
    reset_in = 0;

    // Plain make/break
    send(8'h1C);
    chk("avail_at_k1", {31'd0, kbd_available}, 32'd0);
    chk("key_down_make", {31'd0, key_down}, 32'd1);
    idle(1);
    chk("entry_1C", {19'd0, ev_flags, ev_code}, {19'd0, 5'b00000, 8'h1C});
    send(8'hF0); send(8'h1C);
    chk("key_down_break", {31'd0, key_down}, 32'd0);
    pop();

    // Shifted key
    send(8'h12);
    chk("shift_rise", {31'd0, shift}, 32'd1);
    send(8'h1C); send(8'hF0); send(8'h1C); idle(1);
    chk("entry_shift_1C", {19'd0, ev_flags, ev_code}, {19'd0, 5'b00001, 8'h1C});
    pop();
    send(8'hF0); send(8'h12);
    chk("shift_clear", {31'd0, shift}, 32'd0);

    // Extended key, non-extended break must not release it
    send(8'hE0); send(8'h75); idle(1);
    chk("entry_ext_75", {19'd0, ev_flags, ev_code}, {19'd0, 5'b01000, 8'h75});
    pop();
    send(8'hF0); send(8'h75);
    chk("plain_brk_keeps", {31'd0, key_down}, 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_brk_clears", {31'd0, key_down}, 32'd0);

    // Auto-repeat with prompt pops
    na = 0;
    send(8'h1C);
    for (int i = 0; i < 24; i++) begin
      if (kbd_available && na < 8) begin tm[na] = cyc; fl[na] = ev_flags; na++; end
      step(0, 8'h00, 0, kbd_available, 0);
    end
    chk("rep_gap_first", tm[1] - tm[0], 32'd10);
    chk("rep_gap_second", tm[2] - tm[1], 32'd4);
    chk("rep_gap_third", tm[3] - tm[2], 32'd4);
    chk("rep_flag_make", {27'd0, fl[0]}, 32'd0);
    chk("rep_flag_rep", {27'd0, fl[1]}, {27'd0, 5'b10000});
    // No pops: later repeats are skipped while the queue is occupied
    idle(30);
    send(8'hF0); send(8'h1C);
    chk("held_rep_flags", {27'd0, ev_flags}, {27'd0, 5'b10000});
    cnt = 0;
    for (int i = 0; i < 10 && kbd_available; i++) begin cnt++; pop(); end
    chk("held_rep_count", cnt, 32'd1);

    // Overflow
    for (int i = 0; i < 9; i++) send(ovf_codes[i]);
    idle(2);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", {24'd0, ev_code}, {24'd0, ovf_codes[i]});
      pop();
    end
    chk("ovf_retained_4", {31'd0, kbd_available}, 32'd0);
    send(8'hF0); send(8'h44);
    step(0, 8'h00, 0, 0, 1);
    chk("overflow_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) send(pool[i]);
    idle(1);
    send(8'h4B);
    pop();
    chk("full_push_pop_no_ovf", {31'd0, overflow}, 32'd0);
    chk("full_push_pop_head", {24'd0, ev_code}, 32'h1B);
    drain();
    send(8'hF0); send(8'h4B); idle(2); drain();

    // Pause sequence and STOP pulse
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(2);
    chk("pause_no_entry", {30'd0, kbd_available, ctrl}, 32'd0);
    send(8'h07);
    hc = key_stop ? 1 : 0;
    for (int i = 0; i < 20 && key_stop; i++) begin
      idle(1);
      if (key_stop) hc++;
    end
    chk("stop_pulse_len", hc, PULSE);
    send(8'h12); send(8'h1C); idle(1); send(8'h7E); idle(2);
    reset_in = 1;
    #1;
    chk_zero("reset_mid_pulse");
    model_reset();
    @(posedge mclk);
    #1;
    reset_in = 0;
    check_all();

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3: begin
          b = pool[$urandom_range(0, 3)];
          if ($urandom_range(0, 1) == 0) send_r(b);
          else begin send_r(8'hF0); send_r(b); end
        end
        4: begin
          case ($urandom_range(0, 3))
            0: b = 8'h12;
            1: b = 8'h59;
            2: b = 8'h14;
            default: b = 8'h11;
          endcase
          if ((b == 8'h14 || b == 8'h11) && $urandom_range(0, 1) == 1) send_r(8'hE0);
          if ($urandom_range(0, 1) == 1) send_r(8'hF0);
          send_r(b);
        end
        5: begin
          send_r(8'hE0);
          if ($urandom_range(0, 1) == 1) send_r(8'hF0);
          send_r(8'h75);
        end
        6: begin
          send_r(8'hE0);
          if ($urandom_range(0, 1) == 1) send_r(8'hF0);
          send_r(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
        end
        7: send_r(($urandom_range(0, 1) == 1) ? 8'h07 : 8'h7E);
        8: begin
          send_r(($urandom_range(0, 1) == 1) ? 8'hE0 : 8'hF0);
          if ($urandom_range(0, 1) == 1) step(0, 8'h00, 1, 0, 0);
          else step(1, pool[$urandom_range(0, 3)], 1, 0, 0);
        end
        9: step(0, 8'h00, 0, $urandom_range(0, 1) == 1, 1);
        10: begin
          for (int j = 0; j < int'($urandom_range(1, 14)); j++)
            step(0, 8'h00, 0, $urandom_range(0, 2) == 0, 0);
        end
        default: begin
          send_r(8'hE1); send_r(8'h14); send_r(8'h77); send_r(8'hE1);
          send_r(8'hF0); send_r(8'h14); send_r(8'hF0); send_r(8'h77);
        end
      endcase
    end
    idle(4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
